uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART_TX serializer among NUM_REQ byte sources. Round-robin picks one
//   pending source, latches its byte and that source's parity config, and issues a
//   one-cycle Data_valid launch. It then tracks busy until the frame completes and
//   enforces an idle gap before the next grant. Sits between the requesters and the
//   UART_TX P_DATA/Data_valid/PAR_EN/PAR_TYP inputs.
// PARAMETERS
//   NUM_REQ   4  number of requesters (>=2)
//   ID_W      2  width of GRANT_ID, = clog2(NUM_REQ)
//   BUSY_TO   4  max cycles after launch to wait for busy=1 before timeout (>=1)
//   IDLE_GAP  1  cycles spent in GAP after a frame ends (0 = straight to IDLE)
// PORTS
//   CLK          in   1          clock, all logic on rising edge
//   RST          in   1          asynchronous reset, active-high
//   REQ_VALID    in   NUM_REQ    per-source byte pending; held until REQ_READY
//   REQ_DATA     in   8*NUM_REQ  byte i at [8*i+7:8*i]
//   REQ_READY    out  NUM_REQ    one-cycle accept pulse to the granted source
//   PAR_EN_CFG   in   NUM_REQ    per-source parity enable
//   PAR_TYP_CFG  in   NUM_REQ    per-source parity type (1 = odd)
//   P_DATA       out  8          byte to UART_TX
//   Data_valid   out  1          launch strobe to UART_TX
//   PAR_EN       out  1          parity enable to UART_TX
//   PAR_TYP      out  1          parity type to UART_TX
//   busy         in   1          UART_TX busy
//   GRANT_ID     out  ID_W       index of the current/last granted source
//   ACTIVE       out  1          high in every state except IDLE
//   TO_ERR       out  1          sticky: busy never rose after a launch
//   ERR_CLR      in   1          synchronous clear of TO_ERR
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, last_grant = NUM_REQ-1 (source 0 first).
//     Reset mid-frame aborts immediately. No byte is replayed.
//   All outputs are registered.
//   FSM: IDLE -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> GAP -> IDLE.
//   IDLE: at an edge where |REQ_VALID is true:
//     - pick the first valid source scanning last_grant+1 .. wrapping mod NUM_REQ
//     - latch P_DATA=REQ_DATA[g], PAR_EN=PAR_EN_CFG[g], PAR_TYP=PAR_TYP_CFG[g]
//     - set GRANT_ID=g and last_grant=g, go to LAUNCH
//   LAUNCH: exactly 1 cycle. Data_valid=1 and REQ_READY[g]=1, all other bits 0.
//     Next state is WAIT_BUSY, with its counter cleared.
//   WAIT_BUSY: busy=1 -> WAIT_DONE. Otherwise count; after BUSY_TO cycles
//     without busy -> set TO_ERR, go to GAP. The frame is dropped, not retried.
//   WAIT_DONE: stay while busy=1; busy=0 -> GAP (or IDLE when IDLE_GAP=0).
//   GAP: IDLE_GAP cycles, then IDLE.
//   P_DATA/PAR_EN/PAR_TYP hold their latched values from LAUNCH until the next grant.
//     They never change while busy=1.
//   Config and REQ_DATA changes after the grant edge do not affect the frame in flight.
//   REQ_VALID dropping during LAUNCH has no effect: the byte is already latched.
//   A source that stays valid is granted again only after all other valid sources.
//   TO_ERR: a set and ERR_CLR in the same cycle -> set wins.
//   Latency: REQ_VALID high in IDLE -> Data_valid at the next edge (1 cycle).
// TESTING (bench uses a UART_TX model: busy rises 1 cycle after Data_valid, 10 cycles high)
//   1. Single source: REQ_VALID=4'b0001, byte 8'hA5, parity off.
//      -> REQ_READY[0] and Data_valid pulse 1 cycle, P_DATA=8'hA5, GRANT_ID=0.
//      -> ACTIVE falls IDLE_GAP+1 cycles after busy falls.
//   2. REQ_VALID=4'b1111 held, new bytes 8'h10+i.
//      -> grants 0,1,2,3,0 in order; exactly one Data_valid per busy period.
//   3. Right after a grant to 3, assert REQ_VALID=4'b1010.
//      -> next grant 1, then 3 (round-robin wrap).
//   4. PAR_EN_CFG=PAR_TYP_CFG=4'b0100, source 2 sends 8'h48 into real UART_TX.
//      -> PAR_EN=PAR_TYP=1 for the frame; serial line shows start 0, 0x48 LSB first,
//         parity bit 1, stop bit 1.
//   5. busy tied 0, source 1 valid.
//      -> REQ_READY[1] pulses; TO_ERR=1 BUSY_TO cycles after LAUNCH; FSM returns to IDLE.
//      -> ERR_CLR=1 clears TO_ERR.
//   6. Assert RST while in WAIT_DONE.
//      -> all outputs 0 at once, with no clock edge needed.
//      -> after release with REQ_VALID=4'b1001, source 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, UART_TX and status signals of the UART_TX arbiter
//   REQ_VALID/REQ_DATA/REQ_READY  per-source byte handshake, byte i at [8*i+7:8*i]
//   PAR_EN_CFG/PAR_TYP_CFG        per-source parity config (PAR_TYP 1 = odd)
//   P_DATA/Data_valid/PAR_EN/PAR_TYP/busy  UART_TX side
//   GRANT_ID/ACTIVE/TO_ERR/ERR_CLR         status and sticky timeout error
//   slave modport is the arbiter, master modport is the surrounding system
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   REQ_VALID;
  logic [8*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]   REQ_READY;
  logic [NUM_REQ-1:0]   PAR_EN_CFG;
  logic [NUM_REQ-1:0]   PAR_TYP_CFG;
  logic [7:0]           P_DATA;
  logic                 Data_valid;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic                 busy;
  logic [ID_W-1:0]      GRANT_ID;
  logic                 ACTIVE;
  logic                 TO_ERR;
  logic                 ERR_CLR;
  modport master (
    output REQ_VALID, REQ_DATA, PAR_EN_CFG, PAR_TYP_CFG, busy, ERR_CLR,
    input  REQ_READY, P_DATA, Data_valid, PAR_EN, PAR_TYP, GRANT_ID, ACTIVE, TO_ERR
  );
  modport slave (
    input  REQ_VALID, REQ_DATA, PAR_EN_CFG, PAR_TYP_CFG, busy, ERR_CLR,
    output REQ_READY, P_DATA, Data_valid, PAR_EN, PAR_TYP, GRANT_ID, ACTIVE, TO_ERR
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART_TX among NUM_REQ byte sources
//   CLK  clock, rising edge
//   RST  asynchronous reset, active-high
//   bus  uart_tx_arbiter_if.slave: requester handshake, UART_TX launch, status
//   All bus outputs come straight from flops.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int BUSY_TO  = 4,
  parameter int IDLE_GAP = 1
) (
  input logic CLK,
  input logic RST,
  uart_tx_arbiter_if.slave bus
);
  localparam int CNT_MAX = (BUSY_TO > IDLE_GAP) ? BUSY_TO : IDLE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  localparam state_t POST = (IDLE_GAP == 0) ? IDLE : GAP;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    last_q, last_d, grant_q, grant_d, pick;
  logic [7:0]         data_q, data_d;
  logic               pen_q, pen_d, ptyp_q, ptyp_d, dv_q, dv_d;
  logic               active_q, active_d, to_err_q, to_err_d, timeout;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  int                 idx;
  // Scan from the farthest candidate down to last+1 so the closest valid source wins.
  always_comb begin
    pick = last_q;
    idx  = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (bus.REQ_VALID[idx]) pick = ID_W'(idx);
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    dv_d    = 1'b0;
    ready_d = '0;
    timeout = 1'b0;
    case (state_q)
      IDLE: if (|bus.REQ_VALID) begin
        state_d = LAUNCH;
        last_d  = pick;
        grant_d = pick;
        data_d  = bus.REQ_DATA[8*int'(pick) +: 8];
        pen_d   = bus.PAR_EN_CFG[pick];
        ptyp_d  = bus.PAR_TYP_CFG[pick];
        dv_d    = 1'b1;
        ready_d = NUM_REQ'(1) << pick;
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        timeout = !bus.busy && cnt_q == CNT_W'(BUSY_TO - 1);
        state_d = bus.busy ? WAIT_DONE : timeout ? POST : WAIT_BUSY;
        cnt_d   = timeout ? '0 : cnt_q + 1'b1;
      end
      WAIT_DONE: begin
        state_d = bus.busy ? WAIT_DONE : POST;
        cnt_d   = '0;
      end
      GAP: begin
        state_d = (cnt_q == CNT_W'(IDLE_GAP - 1)) ? IDLE : GAP;
        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    to_err_d = timeout | (to_err_q & ~bus.ERR_CLR);
    active_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= ID_W'(NUM_REQ - 1);
      grant_q  <= '0;
      data_q   <= '0;
      pen_q    <= 1'b0;
      ptyp_q   <= 1'b0;
      dv_q     <= 1'b0;
      ready_q  <= '0;
      active_q <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      pen_q    <= pen_d;
      ptyp_q   <= ptyp_d;
      dv_q     <= dv_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      to_err_q <= to_err_d;
    end
  end
  assign bus.REQ_READY  = ready_q;
  assign bus.P_DATA     = data_q;
  assign bus.Data_valid = dv_q;
  assign bus.PAR_EN     = pen_q;
  assign bus.PAR_TYP    = ptyp_q;
  assign bus.GRANT_ID   = grant_q;
  assign bus.ACTIVE     = active_q;
  assign bus.TO_ERR     = to_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a UART_TX busy model
module tb_uart_tx_arbiter;
  localparam int N        = 4;
  localparam int ID_W     = 2;
  localparam int BUSY_TO  = 4;
  localparam int IDLE_GAP = 1;
  localparam int BUSY_LEN = 10;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      data;
    logic            pen;
    logic            ptyp;
  } exp_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  uart_tx_arbiter_if #(.NUM_REQ(N), .ID_W(ID_W)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .BUSY_TO(BUSY_TO), .IDLE_GAP(IDLE_GAP))
    dut (.CLK(CLK), .RST(RST), .bus(bus));
  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] src_q[N][$];
  int         n_vec = 0;
  int         n_err = 0;
  int         mdl_last = N - 1;
  logic       busy_en = 1'b1;
  int         busy_cnt = 0;
  logic [N-1:0] pen_cfg = '0;
  logic [N-1:0] ptyp_cfg = '0;
  assign bus.busy        = busy_cnt != 0;
  assign bus.PAR_EN_CFG  = pen_cfg;
  assign bus.PAR_TYP_CFG = ptyp_cfg;
  // UART_TX model: busy rises one cycle after Data_valid and stays high BUSY_LEN cycles
  always @(posedge CLK or posedge RST)
    if (RST) busy_cnt <= 0;
    else if (bus.Data_valid && busy_en) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Requesters: each source presents the head of its byte queue, pops on REQ_READY
  always @(negedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (bus.REQ_READY[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      bus.REQ_VALID[i]     = src_q[i].size() != 0;
      bus.REQ_DATA[8*i+:8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'($urandom);
    end
  end
  // Monitor: every launch is compared with the next expected frame
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.Data_valid) begin
        check("launch_not_busy", 32'(bus.busy), 0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_launch: got id %0d, expected no launch", bus.GRANT_ID);
        end else begin
          cur = exp_q.pop_front();
          check("grant_id", 32'(bus.GRANT_ID), 32'(cur.id));
          check("p_data", 32'(bus.P_DATA), 32'(cur.data));
          check("par_en", 32'(bus.PAR_EN), 32'(cur.pen));
          check("par_typ", 32'(bus.PAR_TYP), 32'(cur.ptyp));
          check("req_ready", 32'(bus.REQ_READY), 32'(1) << cur.id);
          check("active_launch", 32'(bus.ACTIVE), 1);
        end
      end else if (bus.busy) check("p_data_hold", 32'(bus.P_DATA), 32'(cur.data));
    end
  end
  // Loads byte queues and predicts grant order: repeated round-robin passes from
  // the last granted source, each pending source sending one byte per pass.
  task automatic issue(input int cnt[N], input int base);
    int left[N];
    logic [7:0] bytes[N][8];
    int tot, seq, s;
    exp_t e;
    tot = 0;
    seq = 0;
    for (int i = 0; i < N; i++) begin
      left[i] = cnt[i];
      tot += cnt[i];
      for (int j = 0; j < cnt[i]; j++) begin
        bytes[i][j] = (base >= 0) ? 8'(base + seq) : 8'($urandom);
        seq++;
        src_q[i].push_back(bytes[i][j]);
      end
    end
    while (tot > 0) begin
      for (int k = 1; k <= N; k++) begin
        s = (mdl_last + k) % N;
        if (left[s] > 0) begin
          e.id   = ID_W'(s);
          e.data = bytes[s][cnt[s] - left[s]];
          e.pen  = pen_cfg[s];
          e.ptyp = ptyp_cfg[s];
          exp_q.push_back(e);
          left[s]--;
          tot--;
          mdl_last = s;
          break;
        end
      end
    end
  endtask
  task automatic wait_dv();
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (bus.Data_valid) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_dv: got no Data_valid, expected one within 100 cycles");
  endtask
  task automatic wait_busy(input logic lvl);
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (bus.busy == lvl) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_busy: got busy stuck, expected %0d within 100 cycles", lvl);
  endtask
  task automatic wait_idle();
    int pend;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      pend = 0;
      for (int i = 0; i < N; i++) pend += src_q[i].size();
      if (pend == 0 && exp_q.size() == 0 && !bus.ACTIVE) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: got still active/pending, expected idle within 3000 cycles");
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected end before 1ms");
    $fatal(1);
  end
  initial begin
    int cnt[N];
    int sum;
    bus.ERR_CLR = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_dv", 32'(bus.Data_valid), 0);
    check("rst_ready", 32'(bus.REQ_READY), 0);
    check("rst_p_data", 32'(bus.P_DATA), 0);
    check("rst_grant", 32'(bus.GRANT_ID), 0);
    check("rst_active", 32'(bus.ACTIVE), 0);
    check("rst_to_err", 32'(bus.TO_ERR), 0);
    check("rst_par", 32'({bus.PAR_EN, bus.PAR_TYP}), 0);
    RST = 1'b0;
    issue('{1, 0, 0, 0}, 'hA5);
    wait_dv();
    wait_busy(1'b1);
    wait_busy(1'b0);
    repeat (IDLE_GAP) @(negedge CLK);
    check("active_gap", 32'(bus.ACTIVE), 1);
    @(negedge CLK);
    check("active_fall", 32'(bus.ACTIVE), 0);
    wait_idle();
    pen_cfg  = 4'b0100;
    ptyp_cfg = 4'b0100;
    issue('{0, 0, 1, 0}, 'h48);
    wait_dv();
    pen_cfg  = '0;
    ptyp_cfg = '0;
    wait_busy(1'b1);
    check("par_en_held", 32'(bus.PAR_EN), 1);
    check("par_typ_held", 32'(bus.PAR_TYP), 1);
    check("p_data_held", 32'(bus.P_DATA), 'h48);
    wait_idle();
    busy_en = 1'b0;
    issue('{0, 1, 0, 0}, -1);
    wait_dv();
    repeat (BUSY_TO) @(negedge CLK);
    check("to_err_early", 32'(bus.TO_ERR), 0);
    @(negedge CLK);
    check("to_err_set", 32'(bus.TO_ERR), 1);
    check("to_active", 32'(bus.ACTIVE), 1);
    repeat (IDLE_GAP) @(negedge CLK);
    check("to_idle", 32'(bus.ACTIVE), 0);
    bus.ERR_CLR = 1'b1;
    @(negedge CLK);
    check("to_err_clr", 32'(bus.TO_ERR), 0);
    bus.ERR_CLR = 1'b0;
    issue('{0, 1, 0, 0}, -1);
    wait_dv();
    bus.ERR_CLR = 1'b1;
    repeat (BUSY_TO + 1) @(negedge CLK);
    check("to_set_wins", 32'(bus.TO_ERR), 1);
    @(negedge CLK);
    check("to_clr_after", 32'(bus.TO_ERR), 0);
    bus.ERR_CLR = 1'b0;
    wait_idle();
    busy_en = 1'b1;
    issue('{1, 0, 0, 0}, -1);
    wait_dv();
    wait_busy(1'b1);
    repeat (2) @(negedge CLK);
    check("pre_rst_active", 32'(bus.ACTIVE), 1);
    #2 RST = 1'b1;
    #1;
    check("arst_active", 32'(bus.ACTIVE), 0);
    check("arst_p_data", 32'(bus.P_DATA), 0);
    check("arst_grant", 32'(bus.GRANT_ID), 0);
    check("arst_misc", 32'({bus.Data_valid, bus.REQ_READY, bus.PAR_EN, bus.PAR_TYP, bus.TO_ERR}), 0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    mdl_last = N - 1;
    @(negedge CLK);
    RST = 1'b0;
    issue('{1, 0, 0, 1}, -1);
    wait_idle();
    issue('{2, 1, 1, 1}, 'h10);
    wait_idle();
    issue('{0, 0, 0, 1}, -1);
    wait_dv();
    @(negedge CLK);
    issue('{0, 1, 0, 1}, -1);
    wait_idle();
    for (int p = 0; p < 40; p++) begin
      pen_cfg  = N'($urandom);
      ptyp_cfg = N'($urandom);
      sum = 0;
      for (int i = 0; i < N; i++) begin
        cnt[i] = $urandom_range(0, 3);
        sum += cnt[i];
      end
      if (sum == 0) cnt[$urandom_range(0, N - 1)] = 1;
      issue(cnt, -1);
      wait_idle();
    end
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
